// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined AES ShiftRows/InvShiftRows for NB = 4/6/8 columns with valid/ready stages.
// Define SHROW_PARITY_EN to carry per-byte odd parity with the data and raise a sticky error flag.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data
`ifdef SHROW_PARITY_EN
    ,
    input  logic [4*NB-1:0]   in_par,
    output logic [4*NB-1:0]   out_par,
    output logic              par_err
`endif
);
    localparam int W      = 32 * NB;
    localparam int NBYTES = 4 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB=%0d is not 4, 6 or 8", NB);
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES=%0d is outside 1..4", STAGES);
    end

    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    // Index of the input byte that lands in output byte i (byte i = row i%4, column i/4).
    function automatic int src_byte(input int i, input bit inv);
        int r;
        int c;
        int sc;
        r  = i % 4;
        c  = i / 4;
        sc = inv ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
        return 4 * sc + r;
    endfunction

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_perm;

`ifdef SHROW_PARITY_EN
    logic [NBYTES-1:0] w_par_fwd;
    logic [NBYTES-1:0] w_par_inv;
    logic [NBYTES-1:0] w_par_perm;
`endif

    for (genvar i = 0; i < NBYTES; i++) begin : g_perm
        localparam int SF = src_byte(i, 1'b0);
        localparam int SI = src_byte(i, 1'b1);
        assign w_fwd[W-1-8*i -: 8] = in_data[W-1-8*SF -: 8];
        assign w_inv[W-1-8*i -: 8] = in_data[W-1-8*SI -: 8];
`ifdef SHROW_PARITY_EN
        assign w_par_fwd[i] = in_par[SF];
        assign w_par_inv[i] = in_par[SI];
`endif
    end

    assign w_perm = in_inv ? w_inv : w_fwd;

    logic [STAGES-1:0] r_valid;
    logic [W-1:0]      r_data [STAGES];
    logic [STAGES-1:0] w_ready;
    logic              w_acc;

    // A stage may load when it is empty or every stage after it can advance.
    // NOTE: each variable driven here is assigned before any branch or loop, so no latch is inferred.
    always_comb begin
        w_acc   = out_ready;
        w_ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc      = w_acc | ~r_valid[k];
            w_ready[k] = w_acc;
        end
    end

    // NOTE: non-blocking assignments let every stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (w_ready[0]) r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (w_ready[k]) r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // NOTE: data registers carry no reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge clk) begin
        if (in_valid && w_ready[0]) r_data[0] <= w_perm;
        for (int k = 1; k < STAGES; k++) begin
            if (r_valid[k-1] && w_ready[k]) r_data[k] <= r_data[k-1];
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];

`ifdef SHROW_PARITY_EN
    logic [NBYTES-1:0] r_par [STAGES];
    logic              w_par_bad;
    logic              r_par_err;

    assign w_par_perm = in_inv ? w_par_inv : w_par_fwd;

    // A byte and its parity bit together must hold an odd number of ones.
    always_comb begin
        w_par_bad = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            w_par_bad = w_par_bad | ~(^{in_data[W-1-8*i -: 8], in_par[i]});
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && w_ready[0]) r_par[0] <= w_par_perm;
        for (int k = 1; k < STAGES; k++) begin
            if (r_valid[k-1] && w_ready[k]) r_par[k] <= r_par[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (in_valid && w_ready[0] && w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end

    assign out_par = r_par[STAGES-1];
    assign par_err = r_par_err;
`endif
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: randomized and directed checks of shift_rows_pipe against a state-matrix model.
// Main instance NB=4/STAGES=3 is scoreboarded every cycle; NB=6 and NB=8 instances cover the other widths.
`timescale 1ns/1ps
module tb_shift_rows_pipe;
    localparam int ST = 3;
    localparam logic [127:0] T1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] T1_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic         a6_in_valid, a6_in_ready, a6_in_inv, a6_out_valid;
    logic [191:0] a6_in_data, a6_out_data;
    logic         a8_in_valid, a8_in_ready, a8_in_inv, a8_out_valid;
    logic [255:0] a8_in_data, a8_out_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  par;
        int           cyc;
    } exp_t;
    exp_t q[$];
    int           cyc = 0;
    bit           chk_lat = 1'b0;
    bit           hold_v = 1'b0;
    logic [127:0] hold_d;

    // Reference: unpack into a 4 x NB state matrix, rotate each row left by its offset (right for inverse).
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input bit inv);
        logic [7:0]   st [4][8];
        logic [255:0] o;
        int           s;
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) st[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) begin
            s = (nb == 8 && r >= 2) ? r + 1 : r;
            if (inv) s = nb - s;
            for (int c = 0; c < nb; c++) o[32*nb-1-8*(4*c+r) -: 8] = st[r][(c + s) % nb];
        end
        return o;
    endfunction

    function automatic logic [255:0] rand256(input int nb);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        for (int k = 32 * nb; k < 256; k++) r[k] = 1'b0;
        return r;
    endfunction

`ifdef SHROW_PARITY_EN
    logic [15:0] in_par, out_par, par_flip;
    logic        par_err;
    logic [23:0] a6_in_par, a6_out_par;
    logic        a6_par_err;
    logic [31:0] a8_in_par, a8_out_par;
    logic        a8_par_err;

    function automatic logic [31:0] odd_par(input int nb, input logic [255:0] d);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 4 * nb; i++) p[i] = ~(^d[32*nb-1-8*i -: 8]);
        return p;
    endfunction

    // Parity bits travel with their bytes: embed each as a byte, reuse the data model, extract.
    function automatic logic [31:0] par_shift(input int nb, input logic [31:0] p, input bit inv);
        logic [255:0] d;
        logic [255:0] o;
        logic [31:0]  r;
        d = '0;
        r = '0;
        for (int i = 0; i < 4 * nb; i++) d[32*nb-1-8*i -: 8] = {7'b0, p[i]};
        o = ref_shift(nb, d, inv);
        for (int i = 0; i < 4 * nb; i++) r[i] = o[32*nb-8-8*i];
        return r;
    endfunction

    assign in_par    = 16'(odd_par(4, {128'b0, in_data})) ^ par_flip;
    assign a6_in_par = 24'(odd_par(6, {64'b0, a6_in_data}));
    assign a8_in_par = odd_par(8, a8_in_data);
`endif

    shift_rows_pipe #(.NB(4), .STAGES(ST)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHROW_PARITY_EN
        , .in_par(in_par), .out_par(out_par), .par_err(par_err)
`endif
    );

    shift_rows_pipe #(.NB(6), .STAGES(1)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(a6_in_valid), .in_ready(a6_in_ready), .in_inv(a6_in_inv),
        .in_data(a6_in_data), .out_valid(a6_out_valid), .out_ready(1'b1), .out_data(a6_out_data)
`ifdef SHROW_PARITY_EN
        , .in_par(a6_in_par), .out_par(a6_out_par), .par_err(a6_par_err)
`endif
    );

    shift_rows_pipe #(.NB(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(a8_in_valid), .in_ready(a8_in_ready), .in_inv(a8_in_inv),
        .in_data(a8_in_data), .out_valid(a8_out_valid), .out_ready(1'b1), .out_data(a8_out_data)
`ifdef SHROW_PARITY_EN
        , .in_par(a8_in_par), .out_par(a8_out_par), .par_err(a8_par_err)
`endif
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare process for the main instance, sampled mid-cycle while inputs are stable.
    task automatic monitor_step();
        exp_t         e;
        logic [255:0] t;
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
            return;
        end
        check("in_ready_vs_occupancy", in_ready, (q.size() < ST) || out_ready);
        if (q.size() == 0) check("idle_out_valid", out_valid, 1'b0);
        if (hold_v) begin
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, hold_d);
        end
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            check("out_data", out_data, e.data);
`ifdef SHROW_PARITY_EN
            check("out_par", out_par, e.par);
`endif
            if (chk_lat) check("latency", cyc - e.cyc, ST);
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        if (in_valid && in_ready) begin
            t      = ref_shift(4, {128'b0, in_data}, in_inv);
            e.data = t[127:0];
            e.par  = '0;
`ifdef SHROW_PARITY_EN
            e.par  = 16'(par_shift(4, {16'b0, in_par}, in_inv));
`endif
            e.cyc  = cyc;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        monitor_step();
    end

    task automatic send(input logic [127:0] d, input bit inv);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_accept", ok, 1'b1);
    endtask

    task automatic wait_out(output logic [127:0] d);
        bit ok = 1'b0;
        d = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ok = 1'b1;
                d  = out_data;
            end
        end
        check("wait_out_timeout", ok, 1'b1);
    endtask

    // One beat through the NB=6 or NB=8 instance (out_ready tied high).
    task automatic xfer(input int nb, input logic [255:0] d, input bit inv, output logic [255:0] res);
        bit ok = 1'b0;
        res = '0;
        @(posedge clk); #1;
        if (nb == 6) begin
            a6_in_valid = 1'b1; a6_in_data = d[191:0]; a6_in_inv = inv;
        end else begin
            a8_in_valid = 1'b1; a8_in_data = d; a8_in_inv = inv;
        end
        @(negedge clk);
        check("xfer_in_ready", (nb == 6) ? a6_in_ready : a8_in_ready, 1'b1);
        @(posedge clk); #1;
        a6_in_valid = 1'b0;
        a8_in_valid = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (nb == 6 && a6_out_valid) begin ok = 1'b1; res = {64'b0, a6_out_data}; end
            if (nb == 8 && a8_out_valid) begin ok = 1'b1; res = a8_out_data; end
        end
        check("xfer_timeout", ok, 1'b1);
    endtask

    initial begin
        logic [127:0] got, f;
        logic [255:0] d, r, b;
        int           cnt, idx;
        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        a6_in_valid = 1'b0; a6_in_inv = 1'b0; a6_in_data = '0;
        a8_in_valid = 1'b0; a8_in_inv = 1'b0; a8_in_data = '0;
`ifdef SHROW_PARITY_EN
        par_flip = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        check("model_t1", ref_shift(4, {128'b0, T1_IN}, 1'b0), {128'b0, T1_OUT});
        check("model_t2", ref_shift(4, {128'b0, T1_OUT}, 1'b1), {128'b0, T1_IN});

        send(T1_IN, 1'b0);  wait_out(got); check("t1_fwd", got, T1_OUT);
        send(T1_OUT, 1'b1); wait_out(got); check("t2_inv", got, T1_IN);

        for (int k = 0; k < 4; k++) begin
            d = rand256(4);
            send(d[127:0], 1'b0); wait_out(f);
            send(f, 1'b1);        wait_out(got);
            check("nb4_round_trip", got, d[127:0]);
        end

        for (int i = 0; i < 32; i++) d[255-8*i -: 8] = 8'(i);
        xfer(8, d, 1'b0, r);
        check("t3_full", r, ref_shift(8, d, 1'b0));
        check("t3_col0", r[255:224], 32'h00050e13);
        check("t3_col7", r[31:0], 32'h1c010a0f);

        for (int k = 0; k < 6; k++) begin
            for (int w = 6; w <= 8; w += 2) begin
                d = rand256(w);
                xfer(w, d, 1'b0, r);
                check("wide_fwd", r, ref_shift(w, d, 1'b0));
                xfer(w, r, 1'b1, b);
                check("wide_round_trip", b, d);
            end
        end

        // Random traffic with random back-pressure on the main instance.
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_inv    = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (ST + 2) @(posedge clk); #1;
        check("random_drained", q.size(), 0);

        chk_lat = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = 1'(k % 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (ST + 1) @(posedge clk); #1;
        chk_lat = 1'b0;
        check("t4_stream_drained", q.size(), 0);

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = 1'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t4_full_in_ready", in_ready, 1'b0);
        check("t4_held_beats", q.size(), ST);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (ST + 2) @(posedge clk); #1;
        check("t4_stall_drained", q.size(), 0);
`ifdef SHROW_PARITY_EN
        check("t6_par_err_clean", par_err, 1'b0);
`endif

        in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_in_ready", in_ready, 1'b1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        cnt = 0; idx = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid) begin cnt++; idx = i; end
        end
        check("t5_beat_count", cnt, 1);
        check("t5_beat_latency", idx, ST);

`ifdef SHROW_PARITY_EN
        check("t6_par_err_zero", par_err, 1'b0);
        par_flip = 16'h0020;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        par_flip = '0;
        @(negedge clk);
        check("t6_par_err_set", par_err, 1'b1);
        repeat (5) @(posedge clk); #1;
        check("t6_par_err_sticky", par_err, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_par_err_cleared", par_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
